// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter that shares the single register-file
//               write port between NUM_REQ requesters. It registers the
//               winning write and drives one decoded write enable per
//               register. Register 0 is hardwired zero and is never enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        freeze,
    output logic [(1<<ADDR_W)-1:0]      ctrl_writeEnable,
    output logic [ADDR_W-1:0]           ctrl_writeReg,
    output logic [DATA_W-1:0]           data_writeReg,
    output logic                        busy
);

    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               valid_q,  valid_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [DATA_W-1:0]  data_q,   data_d;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_gnt_any;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_idx;

    // Cyclic first-valid search starting at the round-robin pointer.
    // Grants are suppressed while frozen or while reset is asserted.
    always_comb begin
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        if (ctrl_reset && !freeze) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (!w_gnt_any && req_valid[w_idx]) begin
                    w_gnt_any      = 1'b1;
                    w_grant[w_idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = w_grant;

    // Next state: capture the granted write; a write to register 0 is
    // consumed (pointer advances) but never becomes a valid output.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                addr_d   = req_addr[k*ADDR_W +: ADDR_W];
                data_d   = req_data[k*DATA_W +: DATA_W];
                valid_d  = (req_addr[k*ADDR_W +: ADDR_W] != '0);
                rr_ptr_d = (k == NUM_REQ-1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // State register with synchronous active-low reset; reset drops any
    // write that was captured in the previous cycle.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // One-hot write-enable decode, gated by the output-stage valid bit.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_we
        assign ctrl_writeEnable[r] = valid_q && (addr_q == ADDR_W'(r));
    end

    assign ctrl_writeReg = addr_q;
    assign data_writeReg = data_q;
    assign busy          = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter with a
//               small register-file model driven by the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                        clock;
    logic                        ctrl_reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        freeze;
    logic [(1<<ADDR_W)-1:0]      ctrl_writeEnable;
    logic [ADDR_W-1:0]           ctrl_writeReg;
    logic [DATA_W-1:0]           data_writeReg;
    logic                        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] regs [1<<ADDR_W];

    regfile_wr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .freeze           (freeze),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model: each register latches the shared data on its enable.
    always @(posedge clock) begin
        for (int r = 0; r < (1<<ADDR_W); r++) begin
            if (ctrl_writeEnable[r]) regs[r] <= data_writeReg;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
        req_valid[i]                 = 1'b1;
    endtask

    initial begin
        ctrl_reset = 1'b0;
        freeze     = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;

        // Reset: outputs zero, no grants even with requests pending
        step();
        req_valid = 4'hF;
        settle();
        check("rst_we",    ctrl_writeEnable, 32'h0);
        check("rst_busy",  {31'b0, busy}, 32'h0);
        check("rst_wreg",  {27'b0, ctrl_writeReg}, 32'h0);
        check("rst_data",  data_writeReg, 32'h0);
        check("rst_ready", {28'b0, req_ready}, 32'h0);
        step();
        req_valid  = '0;
        ctrl_reset = 1'b1;

        // Single write: requester 2 -> reg 7
        set_req(2, 5'd7, 32'hDEADBEEF);
        settle();
        check("t1_ready", {28'b0, req_ready}, 32'h4);
        step();
        req_valid[2] = 1'b0;
        settle();
        check("t1_we",    ctrl_writeEnable, 32'h1 << 7);
        check("t1_data",  data_writeReg, 32'hDEADBEEF);
        check("t1_wreg",  {27'b0, ctrl_writeReg}, 32'd7);
        check("t1_busy",  {31'b0, busy}, 32'h1);
        check("t1_ready0", {28'b0, req_ready}, 32'h0);
        step();
        settle();
        check("t1_idle",  {31'b0, busy}, 32'h0);
        check("t1_we0",   ctrl_writeEnable, 32'h0);
        check("t1_hold",  data_writeReg, 32'hDEADBEEF);

        // Pointer is 3: requester 3 alone, wraps pointer to 0
        set_req(3, 5'd10, 32'h33);
        settle();
        check("wrap_ready", {28'b0, req_ready}, 32'h8);
        step();
        req_valid = '0;

        // Round robin: all valid, registers 1..4
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("rr_ready%0d", k), {28'b0, req_ready}, 32'h1 << (k % 4));
            if (k == 0) check("rr_we0", ctrl_writeEnable, 32'h1 << 10);
            else        check($sformatf("rr_we%0d", k), ctrl_writeEnable, 32'h1 << (((k - 1) % 4) + 1));
            check($sformatf("rr_busy%0d", k), {31'b0, busy}, 32'h1);
            step();
        end
        req_valid = '0;
        settle();
        check("rr_we_last", ctrl_writeEnable, 32'h1 << 1);
        check("rr_data_last", data_writeReg, 32'h100);
        step();
        settle();
        check("rr_idle", {31'b0, busy}, 32'h0);

        // Register 0: requester 1 (pointer 1), consumed silently
        set_req(1, 5'd0, 32'h12345678);
        settle();
        check("r0_ready", {28'b0, req_ready}, 32'h2);
        step();
        req_valid = '0;
        set_req(1, 5'd11, 32'h11);
        set_req(2, 5'd12, 32'h22);
        settle();
        check("r0_we",    ctrl_writeEnable, 32'h0);
        check("r0_busy",  {31'b0, busy}, 32'h0);
        check("r0_data",  data_writeReg, 32'h12345678);
        check("r0_ptr2",  {28'b0, req_ready}, 32'h4);
        step();
        req_valid[2] = 1'b0;
        settle();
        check("r0_next_ready", {28'b0, req_ready}, 32'h2);
        check("r0_we12", ctrl_writeEnable, 32'h1 << 12);
        step();
        req_valid[1] = 1'b0;
        settle();
        check("r0_we11", ctrl_writeEnable, 32'h1 << 11);
        step();

        // Freeze: pointer 2, requester 0 granted, then frozen for 3 cycles
        set_req(0, 5'd6, 32'h66);
        settle();
        check("fz_ready_T", {28'b0, req_ready}, 32'h1);
        step();
        req_valid[0] = 1'b0;
        freeze = 1'b1;
        set_req(3, 5'd8, 32'h88);
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("fz_ready%0d", k), {28'b0, req_ready}, 32'h0);
            check($sformatf("fz_we%0d", k), ctrl_writeEnable, (k == 0) ? (32'h1 << 6) : 32'h0);
            step();
        end
        freeze = 1'b0;
        settle();
        check("fz_release", {28'b0, req_ready}, 32'h8);
        step();
        req_valid[3] = 1'b0;
        settle();
        check("fz_we8", ctrl_writeEnable, 32'h1 << 8);
        step();

        // Reset mid-operation: requester 1 -> reg 9, reset at edge ending T+1
        set_req(1, 5'd9, 32'h99);
        settle();
        check("rm_ready_T", {28'b0, req_ready}, 32'h2);
        step();
        req_valid  = '0;
        ctrl_reset = 1'b0;
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd5, 32'hB);
        settle();
        check("rm_we9",    ctrl_writeEnable, 32'h1 << 9);
        check("rm_ready_rst", {28'b0, req_ready}, 32'h0);
        step();
        ctrl_reset = 1'b1;
        settle();
        check("rm_we_drop", ctrl_writeEnable, 32'h0);
        check("rm_busy",    {31'b0, busy}, 32'h0);
        check("rm_wreg",    {27'b0, ctrl_writeReg}, 32'h0);
        check("rm_ptr0",    {28'b0, req_ready}, 32'h1);
        req_valid[3] = 1'b1;
        #1;
        check("rm_ptr0_r3", {28'b0, req_ready}, 32'h1);
        req_valid[3] = 1'b0;
        #1;

        // Same-address ordering: 0xA then 0xB to register 5
        step();
        req_valid[0] = 1'b0;
        settle();
        check("sa_ready1", {28'b0, req_ready}, 32'h2);
        check("sa_we_a",   ctrl_writeEnable, 32'h1 << 5);
        check("sa_data_a", data_writeReg, 32'hA);
        step();
        req_valid[1] = 1'b0;
        settle();
        check("sa_we_b",   ctrl_writeEnable, 32'h1 << 5);
        check("sa_data_b", data_writeReg, 32'hB);
        step();
        settle();
        check("sa_idle",   {31'b0, busy}, 32'h0);
        check("sa_reg5",   regs[5], 32'hB);
        check("sa_reg7",   regs[7], 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin write-port arbiter and sequencer for the 32-entry register file built from `reg32bit` instances. It shares the single register-file write port between up to NUM_REQ requesters, such as pipeline writeback, the decryption engine and the key loader. It also drives one decoded write-enable per register. All register-file writes pass through this block. It sits between the requesters and the `ctrl_writeEnable` / `data_writeReg` pins of every register.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 5: register index width. The file holds 2^ADDR_W registers.
- DATA_W, 32: data width.

- clock  in  1  System clock. All state updates on the rising edge.
- ctrl_reset  in  1  Reset, synchronous and active-low. Asserted when 0 and sampled on the rising edge of `clock`.
- req_valid  in  NUM_REQ  Per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  Destination index per requester. Requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  Write data per requester. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  Grant, one-hot or zero. Combinational.
- freeze  in  1  When 1, no new grants are issued.
- ctrl_writeEnable  out  2^ADDR_W  Decoded one-hot write enable, wired to each `reg32bit` enable. Registered.
- ctrl_writeReg  out  ADDR_W  Index of the issued write. Registered.
- data_writeReg  out  DATA_W  Data of the issued write, shared by all registers. Registered.
- busy  out  1  High when the output stage holds a write this cycle.

## Operation
- State:
  - Round-robin pointer `rr_ptr`, range 0..NUM_REQ-1.
  - Output stage: valid bit, address, data.
- Arbitration, combinational each cycle:
  - If `freeze` = 0 and `ctrl_reset` = 1, grant the first requester with `req_valid` = 1, searching cyclically from `rr_ptr`.
  - `req_ready` has exactly that bit set. All other bits are 0.
  - `req_ready[i]` = 1 only when `req_valid[i]` = 1.
- Transfer: occurs when `req_valid[i]` and `req_ready[i]` are both 1 at a rising edge. On that edge:
  - `rr_ptr` ← (i+1) mod NUM_REQ.
  - The output stage captures `req_addr` and `req_data` of requester i.
  - The output valid bit ← (address != 0).
- No transfer: output valid ← 0 and `rr_ptr` holds.
- Register 0 is hardwired zero:
  - A transfer to index 0 is accepted, consumes the grant and advances `rr_ptr`.
  - It never raises any `ctrl_writeEnable` bit.
  - `busy` stays 0 for it.
- Outputs:
  - `ctrl_writeEnable` = one-hot(`ctrl_writeReg`) when output valid, else all 0.
  - `busy` = output valid.
  - `data_writeReg` and `ctrl_writeReg` hold their last captured values when not valid.
- Only one write per cycle is possible. No two requesters ever see `req_ready` = 1 simultaneously.
- Duplicate addresses: if two requesters target the same register, they write in grant order. The later write wins.
- `freeze` = 1:
  - `req_ready` = 0.
  - A write already captured still issues in the following cycle.
  - `rr_ptr` holds.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until granted. `req_valid` is not retracted before grant.

## Timing
- Reset (`ctrl_reset` = 0 at an edge):
  - `rr_ptr` ← 0, output valid ← 0, `ctrl_writeReg` ← 0, `data_writeReg` ← 0.
  - Therefore `ctrl_writeEnable` = 0 and `busy` = 0.
  - While `ctrl_reset` = 0, `req_ready` = 0.
- Reset mid-operation: a write captured in the previous cycle is dropped. Its `ctrl_writeEnable` pulse is suppressed from the reset edge onward.
- Latency, for a grant in cycle T:
  - The transfer occurs at the edge ending T.
  - `ctrl_writeEnable` is high throughout cycle T+1.
  - The target `reg32bit` updates at the edge ending T+1.
  - The new value is readable in cycle T+2.
- Throughput: one write per cycle. Back-to-back grants produce a continuous `busy`, with `ctrl_writeEnable` moving between indices each cycle.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles of raising `req_valid`, provided `freeze` = 0.
- Wrap-around: pointer NUM_REQ-1 followed by a grant to NUM_REQ-1 gives `rr_ptr` = 0.

## Test plan
- Reset and single write:
  - Stimulus: hold `ctrl_reset` = 0 for 2 cycles, then release.
  - Stimulus: requester 2 writes 0xDEADBEEF to register 7.
  - Required: all outputs are 0 during reset.
  - Required: `req_ready` = 0100b in the cycle of the request.
  - Required: next cycle, `ctrl_writeEnable` = 1<<7, `data_writeReg` = 0xDEADBEEF, `busy` = 1.
  - Required: the following cycle, `busy` = 0.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, writing registers 1..4.
  - Required: grants in order 0,1,2,3,0.
  - Required: `ctrl_writeEnable` sequence 1<<1, 1<<2, 1<<3, 1<<4 on consecutive cycles.
  - Required: `busy` stays high.
- Register 0:
  - Stimulus: requester 1 writes 0x12345678 to register 0.
  - Required: the grant is issued and `rr_ptr` becomes 2.
  - Required: `ctrl_writeEnable` = 0 and `busy` = 0 the next cycle.
- Freeze:
  - Stimulus: requester 0 is granted in cycle T. `freeze` = 1 in T+1..T+3 while requester 3 is valid.
  - Required: requester 0's write issues in T+1.
  - Required: `req_ready` = 0 during T+1..T+3.
  - Required: requester 3 is granted in the first cycle after `freeze` falls.
- Reset mid-operation:
  - Stimulus: grant requester 1 (register 9) in cycle T, then `ctrl_reset` = 0 at the edge ending T+1.
  - Required: `ctrl_writeEnable` = 1<<9 in cycle T+1 only, and 0 from T+2.
  - Required: `rr_ptr` = 0 afterwards, so the next simultaneous request from requesters 0 and 1 grants 0.
- Same-address ordering:
  - Stimulus: requesters 0 and 1 both write register 5, with data 0xA and 0xB.
  - Required: 0xA issues first, then 0xB.
  - Required: register 5 reads 0xB afterwards.
